tehb_fifo: RTL and testbench

Multi-slot transparent elastic buffer for the handshake dataflow library. It breaks the ready path between consumer and producer: `ins_ready` depends only on registered state. Data and valid pass through combinationally whenever the buffer is empty. It is the ready-cutting counterpart of the valid-cutting opaque half buffer, and the two are chained to fully decouple a channel.

---
 rtl/tehb_fifo.sv | 77 +++++++
 tb/tb_tehb_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tehb_fifo.sv
// Multi-slot transparent elastic buffer: cuts the ready path with a circular store,
// while valid/data bypass combinationally whenever the store is empty.
module tehb_fifo #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    localparam int unsigned PtrW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CntW = $clog2(NUM_SLOTS + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(NUM_SLOTS - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(NUM_SLOTS);

    logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
    logic [PtrW-1:0]      head_q, head_d;
    logic [PtrW-1:0]      tail_q, tail_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 empty, full;
    logic                 wr_en, rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCnt);

    // ins_ready must see registered state only, never outs_ready.
    assign ins_ready  = ~full;
    assign outs_valid = ~empty | ins_valid;
    assign outs       = empty ? ins : mem_q[head_q];

    // A bypassed token (empty and consumer ready) is never stored.
    assign wr_en = ins_valid & ~full & ~(empty & outs_ready);
    assign rd_en = outs_ready & ~empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rd_en) begin
            head_d = (head_q == LastPtr) ? '0 : head_q + PtrW'(1);
        end
        if (wr_en) begin
            tail_d = (tail_q == LastPtr) ? '0 : tail_q + PtrW'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_q] <= ins;
        end
    end

endmodule

// File: tb/tb_tehb_fifo.sv
// Self-checking bench for tehb_fifo: directed vector table on a 4-slot instance,
// hand sequences for reset, and a randomly stalled stream through a 3-slot instance.
module tb_tehb_fifo;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic [W-1:0] a_ins = '0;
    logic         a_ins_valid = 1'b0;
    logic         a_ins_ready;
    logic [W-1:0] a_outs;
    logic         a_outs_valid;
    logic         a_outs_ready = 1'b0;

    logic [W-1:0] b_ins = '0;
    logic         b_ins_valid = 1'b0;
    logic         b_ins_ready;
    logic [W-1:0] b_outs;
    logic         b_outs_valid;
    logic         b_outs_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tehb_fifo #(.NUM_SLOTS(4), .DATA_TYPE(W)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .ins        (a_ins),
        .ins_valid  (a_ins_valid),
        .ins_ready  (a_ins_ready),
        .outs       (a_outs),
        .outs_valid (a_outs_valid),
        .outs_ready (a_outs_ready)
    );

    tehb_fifo #(.NUM_SLOTS(3), .DATA_TYPE(W)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .ins        (b_ins),
        .ins_valid  (b_ins_valid),
        .ins_ready  (b_ins_ready),
        .outs       (b_outs),
        .outs_valid (b_outs_valid),
        .outs_ready (b_outs_ready)
    );

    typedef struct {
        logic         iv;
        logic [W-1:0] din;
        logic         ordy;
        logic         exp_irdy;
        logic         exp_ovld;
        logic [W-1:0] exp_dout;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle on instance A between edges and check its combinational outputs.
    task automatic apply_a(input int idx, input vec_t v);
        @(negedge clk);
        a_ins_valid  = v.iv;
        a_ins        = v.din;
        a_outs_ready = v.ordy;
        #1;
        check("ins_ready", idx, int'(a_ins_ready), int'(v.exp_irdy));
        check("outs_valid", idx, int'(a_outs_valid), int'(v.exp_ovld));
        if (v.exp_ovld) check("outs", idx, int'(a_outs), int'(v.exp_dout));
    endtask

    initial begin
        int next_in;
        int next_out;
        int cycles;
        logic irdy_prev;

        // iv, din, ordy, exp_ins_ready, exp_outs_valid, exp_outs
        vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5}; // bypass
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00}; // still empty
        vecs[2]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01}; // fill 1..4
        vecs[3]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01};
        vecs[4]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01};
        vecs[5]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01};
        vecs[6]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01}; // full
        vecs[7]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 8'h01}; // read while full
        vecs[8]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h02}; // 5 accepted
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00}; // drained
        vecs[14] = '{1'b1, 8'h0A, 1'b0, 1'b1, 1'b1, 8'h0A}; // store 10, 11
        vecs[15] = '{1'b1, 8'h0B, 1'b0, 1'b1, 1'b1, 8'h0A};
        vecs[16] = '{1'b1, 8'h0C, 1'b1, 1'b1, 1'b1, 8'h0A}; // read 10, write 12
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0B};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0B};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0C};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};

        // Held in reset: transparent, ready.
        #2;
        a_ins_valid = 1'b1;
        a_ins       = 8'h3C;
        #1;
        check("rst_ins_ready", 0, int'(a_ins_ready), 1);
        check("rst_outs_valid", 0, int'(a_outs_valid), 1);
        check("rst_outs", 0, int'(a_outs), 32'h3C);
        @(negedge clk);
        a_ins_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 21; i++) apply_a(i, vecs[i]);

        // Two tokens stored, then reset asserted between edges.
        apply_a(100, '{1'b1, 8'h21, 1'b0, 1'b1, 1'b1, 8'h21});
        apply_a(101, '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h21});
        @(negedge clk);
        a_ins_valid = 1'b0;
        a_outs_ready = 1'b0;
        #1;
        check("pre_rst_outs_valid", 102, int'(a_outs_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_ins_ready", 103, int'(a_ins_ready), 1);
        check("mid_rst_outs_valid", 103, int'(a_outs_valid), 0);
        a_ins_valid = 1'b1;
        a_ins       = 8'h77;
        #1;
        check("mid_rst_outs_valid", 104, int'(a_outs_valid), 1);
        check("mid_rst_outs", 104, int'(a_outs), 32'h77);
        @(negedge clk);
        rst = 1'b0;
        a_ins_valid = 1'b0;
        apply_a(105, '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33});
        apply_a(106, '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00});

        // Randomly stalled stream 0..99 through the 3-slot instance.
        next_in  = 0;
        next_out = 0;
        cycles   = 0;
        while (next_out < 100 && cycles < 3000) begin
            @(negedge clk);
            irdy_prev    = b_ins_ready;
            b_ins_valid  = (next_in < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_ins        = W'(next_in);
            b_outs_ready = 1'($urandom_range(0, 1));
            #1;
            check("ins_ready_stable", cycles, int'(b_ins_ready), int'(irdy_prev));
            if (b_outs_valid && b_outs_ready) begin
                check("stream_outs", next_out, int'(b_outs), next_out);
                next_out++;
            end
            if (b_ins_valid && b_ins_ready) next_in++;
            cycles++;
        end
        check("stream_done", cycles, next_out, 100);

        @(negedge clk);
        b_ins_valid  = 1'b0;
        b_outs_ready = 1'b0;
        #1;
        check("stream_empty", 0, int'(b_outs_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
